// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared CPU-side bus: round-robin or fixed-priority grant,
// bounded tenure with lock override, and one-cycle-delayed read-data steering.
module bus_arbiter #(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [2:0]  m0_ctrl,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [2:0]  m1_ctrl,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [2:0]  bus_ctrl,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  owner
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [HW-1:0]   hold_cnt;
  logic            last_owner;
  logic [1:0]      prev_owner;
  logic            hold_done;

  // Tenure expires only when preemption is enabled and the counter has saturated.
  assign hold_done = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);

  // Handshake: a master holds req high for its whole tenure; gnt is the registered
  // answer and an access happens only in cycles where gnt=1 and its ctrl is nonzero.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req)
          next_state = ((RR_EN != 0) && !last_owner) ? OWN1 : OWN0;
        else if (m0_req)
          next_state = OWN0;
        else if (m1_req)
          next_state = OWN1;
      end
      OWN0: begin
        if (!m0_req)
          next_state = m1_req ? OWN1 : IDLE;
        else if (m1_req && !m0_lock && hold_done)
          next_state = OWN1;
      end
      OWN1: begin
        if (!m1_req)
          next_state = m0_req ? OWN0 : IDLE;
        else if (m0_req && !m1_lock && hold_done)
          next_state = OWN0;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      prev_owner <= 2'b00;
    end else begin
      state      <= next_state;
      m0_gnt     <= (next_state == OWN0);
      m1_gnt     <= (next_state == OWN1);
      prev_owner <= {m1_gnt, m0_gnt};
      if (next_state != state)
        hold_cnt <= '0;
      else if ((state != IDLE) && (hold_cnt != HOLD_SAT))
        hold_cnt <= hold_cnt + HW'(1);
      if ((next_state == OWN0) && (state != OWN0))
        last_owner <= 1'b0;
      else if ((next_state == OWN1) && (state != OWN1))
        last_owner <= 1'b1;
    end
  end

  assign owner = {m1_gnt, m0_gnt};

  // Bus mux driven from the state register, so requests never reach the bus combinationally.
  always_comb begin
    bus_addr  = 32'h0;
    bus_ctrl  = 3'b000;
    bus_wdata = 32'h0;
    case (state)
      OWN0: begin
        bus_addr  = m0_addr;
        bus_ctrl  = m0_ctrl;
        bus_wdata = m0_wdata;
      end
      OWN1: begin
        bus_addr  = m1_addr;
        bus_ctrl  = m1_ctrl;
        bus_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  // Read data belongs to whoever owned the bus in the issue cycle.
  assign m0_rdata = prev_owner[0] ? bus_rdata : 32'h0;
  assign m1_rdata = prev_owner[1] ? bus_rdata : 32'h0;

endmodule
